phase_sweep: RTL and testbench
==============================

PHASE_SWEEP -- requirements
Module: phase_sweep

Interface
REQ-001 SHALL have parameter PW, default 19: phase-increment width (bits), matching the downstream NCO/CORDIC phase accumulator.
REQ-002 SHALL have parameter DW, default 16: dwell-counter width (bits).
REQ-003 sys_clk  in  1  single clock; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 manual_inc  in  PW  CPU phase increment used when no sweep is active.
REQ-006 f_start  in  PW  sweep start increment.
REQ-007 f_stop  in  PW  sweep end increment (inclusive bound).
REQ-008 f_step  in  PW  increment added per step.
REQ-009 dwell  in  DW  extra cycles each increment is held; a segment lasts dwell+1 cycles.
REQ-010 cont  in  1  1 = continuous (wrap to f_start), 0 = single-shot.
REQ-011 start  in  1  one-cycle start pulse.
REQ-012 abort  in  1  one-cycle abort pulse.
REQ-013 phase_inc  out  PW  registered increment to the NCO/CORDIC stage.
REQ-014 step_strobe  out  1  one-cycle pulse in the first cycle each new sweep value appears on phase_inc.
REQ-015 busy  out  1  high while in DWELL.
REQ-016 done  out  1  one-cycle pulse on single-shot completion.
REQ-017 err  out  1  one-cycle pulse on a rejected start.

Function
REQ-018 SHALL implement FSM states IDLE, DWELL and HOLD.
REQ-019 In IDLE, phase_inc SHALL load manual_inc every cycle (1-cycle latency).
REQ-020 A start in IDLE or HOLD with f_step==0 or f_start>f_stop (unsigned) SHALL be rejected: err pulses next cycle, state becomes or stays IDLE.
REQ-021 A valid start at cycle T SHALL shadow f_start, f_stop, f_step, dwell and cont.
REQ-022 At T+1 after a valid start: phase_inc=f_start, step_strobe=1, busy=1, counter=dwell, state=DWELL.
REQ-023 Input changes during DWELL or HOLD SHALL have no effect until the next accepted start.
REQ-024 In DWELL with counter!=0, the counter SHALL decrement by 1 per cycle while phase_inc holds.
REQ-025 In DWELL with counter==0: next = phase_inc + f_step, computed PW+1 bits wide.
REQ-026 If next <= f_stop with no carry: phase_inc=next, step_strobe=1, counter reloaded.
REQ-027 If next > f_stop or carries out, and cont=1: phase_inc=f_start, step_strobe=1, counter reloaded, stay in DWELL; modulo wrap is never allowed.
REQ-028 If next > f_stop or carries out, and cont=0: go to HOLD, phase_inc holds its last value, busy=0, done pulses for 1 cycle.
REQ-029 start SHALL be ignored in DWELL.
REQ-030 abort in any state SHALL force IDLE at the next edge, with phase_inc=manual_inc, busy=0, and no done pulse.
REQ-031 abort SHALL take priority over start in the same cycle.
REQ-032 done, err and step_strobe SHALL never be high for 2 consecutive cycles except step_strobe when dwell=0.

Reset
REQ-033 While rst_n=0: state=IDLE, phase_inc=0, busy=0, done=0, err=0, step_strobe=0, counter and shadows 0.
REQ-034 Reset asserted mid-sweep SHALL abandon the sweep immediately and asynchronously; the first edge after release SHALL load manual_inc.

Verification
REQ-035 Single sweep: f_start=100, f_stop=130, f_step=10, dwell=2, cont=0 -> phase_inc 100,110,120,130, each 3 cycles with step_strobe in each first cycle; done 1 cycle on HOLD entry; phase_inc stays 130.
REQ-036 Continuous: f_start=0, f_stop=20, f_step=10, dwell=0, cont=1 -> phase_inc 0,10,20,0,10,... one value per cycle; step_strobe constantly high; busy=1; done never pulses.
REQ-037 Overflow: PW=19, f_start=0x7FFF0, f_stop=0x7FFFF, f_step=0x10, cont=0 -> 0x7FFF0 for dwell+1 cycles, then HOLD at 0x7FFF0 with done pulse; 0x00000 never appears.
REQ-038 Rejects: f_step=0, or f_start=50 with f_stop=40 -> err pulse; busy stays 0; phase_inc tracks manual_inc=7.
REQ-039 Abort: abort and start together at step 2 of REQ-035 -> next cycle IDLE, phase_inc=manual_inc, busy=0, no done; the start is ignored.
REQ-040 Reset mid-sweep: rst_n low for 3 cycles during DWELL -> outputs 0 immediately; after release phase_inc=manual_inc; a new start runs the full sweep from f_start.

Source files
------------

// File: rtl/phase_sweep.sv
// Phase-increment sweep generator for an NCO/CORDIC stage: holds a CPU-set increment
// when idle, otherwise steps f_start..f_stop by f_step with a programmable dwell.
module phase_sweep #(
  parameter int PW = 19,
  parameter int DW = 16
) (
  input  logic          sys_clk,
  input  logic          rst_n,
  input  logic [PW-1:0] manual_inc,
  input  logic [PW-1:0] f_start,
  input  logic [PW-1:0] f_stop,
  input  logic [PW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  input  logic          cont,
  input  logic          start,
  input  logic          abort,
  output logic [PW-1:0] phase_inc,
  output logic          step_strobe,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    fsm_state
);

  // start and abort are single-cycle pulses sampled on the rising edge; there is no
  // ready/acknowledge, so a start arriving in DWELL is simply dropped.
  typedef enum logic [1:0] {IDLE = 2'd0, DWELL = 2'd1, HOLD = 2'd2} state_t;

  state_t        state;
  logic [PW-1:0] start_s, stop_s, step_s;
  logic [DW-1:0] dwell_s, cnt;
  logic          cont_s;
  logic [PW:0]   next_inc;
  logic          step_fits;
  logic          start_ok;

  // One extra bit catches carry-out so the increment never wraps modulo 2^PW.
  assign next_inc  = {1'b0, phase_inc} + {1'b0, step_s};
  assign step_fits = !next_inc[PW] && (next_inc[PW-1:0] <= stop_s);
  assign start_ok  = (f_step != '0) && (f_start <= f_stop);
  assign fsm_state = state;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase_inc   <= '0;
      step_strobe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cnt         <= '0;
      start_s     <= '0;
      stop_s      <= '0;
      step_s      <= '0;
      dwell_s     <= '0;
      cont_s      <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        phase_inc <= manual_inc;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE, HOLD: begin
            if (start && start_ok) begin
              start_s     <= f_start;
              stop_s      <= f_stop;
              step_s      <= f_step;
              dwell_s     <= dwell;
              cont_s      <= cont;
              phase_inc   <= f_start;
              step_strobe <= 1'b1;
              busy        <= 1'b1;
              cnt         <= dwell;
              state       <= DWELL;
            end else if (start) begin
              err       <= 1'b1;
              state     <= IDLE;
              phase_inc <= manual_inc;
            end else if (state == IDLE) begin
              phase_inc <= manual_inc;
            end
          end
          DWELL: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (step_fits) begin
              phase_inc   <= next_inc[PW-1:0];
              step_strobe <= 1'b1;
              cnt         <= dwell_s;
            end else if (cont_s) begin
              phase_inc   <= start_s;
              step_strobe <= 1'b1;
              cnt         <= dwell_s;
            end else begin
              state <= HOLD;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_sweep.sv
// Bench for phase_sweep: directed scenarios plus randomized sweeps checked against
// a list-expansion reference model of the expected per-cycle outputs.
module tb_phase_sweep;
  localparam int PW = 19;
  localparam int DW = 16;
  localparam int W  = PW + 4;
  localparam longint MAXV = (64'd1 << PW) - 1;

  logic          sys_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] manual_inc = '0, f_start = '0, f_stop = '0, f_step = '0;
  logic [DW-1:0] dwell = '0;
  logic          cont = 1'b0, start = 1'b0, abort = 1'b0;
  logic [PW-1:0] phase_inc;
  logic          step_strobe, busy, done, err;
  logic [1:0]    fsm_state;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  want;
  int            n_tests = 0;
  int            n_fail = 0;
  int            cyc;

  phase_sweep #(.PW(PW), .DW(DW)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .manual_inc(manual_inc),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .cont(cont), .start(start), .abort(abort), .phase_inc(phase_inc),
    .step_strobe(step_strobe), .busy(busy), .done(done), .err(err),
    .fsm_state(fsm_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Observed outputs packed as {busy, step_strobe, done, err, phase_inc}.
  function automatic logic [W-1:0] obs();
    return {busy, step_strobe, done, err, phase_inc};
  endfunction

  function automatic logic [W-1:0] pack(bit b, bit s, bit d, bit e, logic [PW-1:0] p);
    return {b, s, d, e, p};
  endfunction

  // Expected outputs for n cycles after an accepted start: expand the value list,
  // hold each value d+1 cycles, then either repeat (continuous) or park with done.
  function automatic void build_sweep(longint s, longint e, longint st, int d, bit c, int n);
    longint vals[$];
    longint v;
    int     idx, k;
    bit     first_hold;
    v = s;
    while (v <= e) begin
      vals.push_back(v);
      v += st;
    end
    idx = 0; k = 0; first_hold = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (idx < int'(vals.size())) begin
        exp_q.push_back(pack(1'b1, k == 0, 1'b0, 1'b0, PW'(vals[idx])));
        k++;
        if (k > d) begin
          k = 0;
          idx++;
          if (c && idx == int'(vals.size())) idx = 0;
        end
      end else begin
        exp_q.push_back(pack(1'b0, 1'b0, first_hold, 1'b0, PW'(vals[vals.size()-1])));
        first_hold = 1'b0;
      end
    end
  endfunction

  task automatic launch(longint s, longint e, longint st, int d, bit c);
    f_start = PW'(s); f_stop = PW'(e); f_step = PW'(st);
    dwell = DW'(d); cont = c; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic go_idle();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_reset();
    manual_inc = 19'h1234;
    step();
    step();
    n_tests++;
    if (obs() !== pack(0, 0, 0, 0, '0)) begin
      n_fail++;
      $display("FAIL reset got %h want %h", obs(), pack(0, 0, 0, 0, '0));
    end
    rst_n = 1'b1;
    manual_inc = 19'h123;
    step();
    n_tests++;
    if (obs() !== pack(0, 0, 0, 0, 19'h123)) begin
      n_fail++;
      $display("FAIL reset_release got %h want %h", obs(), pack(0, 0, 0, 0, 19'h123));
    end
  endtask

  task automatic test_manual();
    for (int i = 0; i < 8; i++) begin
      manual_inc = PW'($urandom);
      want = pack(0, 0, 0, 0, manual_inc);
      step();
      n_tests++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL manual c%0d got %h want %h", i, obs(), want);
      end
    end
  endtask

  task automatic test_single();
    manual_inc = 19'd5;
    build_sweep(100, 130, 10, 2, 0, 15);
    build_sweep(0, 20, 10, 0, 0, 5);
    launch(100, 130, 10, 2, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_tests++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL single c%0d got %h want %h", cyc, obs(), want);
      end
      cyc++;
      if (cyc == 15) launch(0, 20, 10, 0, 0);
      else if (exp_q.size() > 0) step();
    end
    go_idle();
  endtask

  task automatic test_continuous();
    build_sweep(0, 20, 10, 0, 1, 12);
    launch(0, 20, 10, 0, 1);
    cyc = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_tests++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL continuous c%0d got %h want %h", cyc, obs(), want);
      end
      cyc++;
      if (exp_q.size() > 0) step();
    end
    go_idle();
  endtask

  task automatic test_overflow();
    build_sweep(19'h7FFF0, 19'h7FFFF, 19'h10, 3, 0, 8);
    launch(19'h7FFF0, 19'h7FFFF, 19'h10, 3, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_tests++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL overflow c%0d got %h want %h", cyc, obs(), want);
      end
      cyc++;
      if (cyc == 8) begin
        build_sweep(19'h7FFF0, 19'h7FFFF, 19'h10, 1, 1, 8);
        launch(19'h7FFF0, 19'h7FFFF, 19'h10, 1, 1);
      end else if (exp_q.size() > 0) step();
    end
    go_idle();
  endtask

  task automatic test_reject();
    manual_inc = 19'd7;
    exp_q.push_back(pack(0, 0, 0, 1, 19'd7));
    exp_q.push_back(pack(0, 0, 0, 0, 19'd7));
    exp_q.push_back(pack(0, 0, 0, 1, 19'd7));
    exp_q.push_back(pack(0, 0, 0, 0, 19'd7));
    exp_q.push_back(pack(0, 0, 0, 0, 19'd7));
    f_start = 19'd10; f_stop = 19'd20; f_step = '0; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_tests++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL reject c%0d got %h want %h", cyc, obs(), want);
      end
      cyc++;
      if (cyc == 2) begin
        f_start = 19'd50; f_stop = 19'd40; f_step = 19'd1; start = 1'b1;
        step();
        start = 1'b0;
      end else if (exp_q.size() > 0) step();
    end
    // f_start == f_stop is a legal one-value sweep; a bad start from HOLD is rejected.
    build_sweep(40, 40, 1, 1, 0, 4);
    launch(40, 40, 1, 1, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_tests++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL equal_bounds c%0d got %h want %h", cyc, obs(), want);
      end
      cyc++;
      if (exp_q.size() > 0) step();
    end
    f_step = '0; start = 1'b1;
    step();
    start = 1'b0;
    n_tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_reject got err=%b busy=%b want err=1 busy=0", err, busy);
    end
    step();
    n_tests++;
    if (obs() !== pack(0, 0, 0, 0, 19'd7)) begin
      n_fail++;
      $display("FAIL hold_reject_idle got %h want %h", obs(), pack(0, 0, 0, 0, 19'd7));
    end
  endtask

  task automatic test_abort();
    manual_inc = 19'd9;
    build_sweep(100, 130, 10, 2, 0, 4);
    exp_q.push_back(pack(0, 0, 0, 0, 19'd9));
    exp_q.push_back(pack(0, 0, 0, 0, 19'd9));
    exp_q.push_back(pack(0, 0, 0, 0, 19'd9));
    launch(100, 130, 10, 2, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_tests++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL abort c%0d got %h want %h", cyc, obs(), want);
      end
      cyc++;
      abort = (cyc == 4);
      start = (cyc == 4);
      if (exp_q.size() > 0) step();
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    manual_inc = 19'd3;
    build_sweep(100, 130, 10, 2, 0, 5);
    launch(100, 130, 10, 2, 0);
    cyc = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_tests++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL pre_reset c%0d got %h want %h", cyc, obs(), want);
      end
      cyc++;
      if (exp_q.size() > 0) step();
    end
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (obs() !== pack(0, 0, 0, 0, '0)) begin
        n_fail++;
        $display("FAIL mid_reset c%0d got %h want %h", i, obs(), pack(0, 0, 0, 0, '0));
      end
      if (i < 3) step();
    end
    rst_n = 1'b1;
    manual_inc = 19'h42;
    exp_q.push_back(pack(0, 0, 0, 0, 19'h42));
    step();
    build_sweep(100, 130, 10, 2, 0, 15);
    cyc = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      n_tests++;
      if (obs() !== want) begin
        n_fail++;
        $display("FAIL post_reset c%0d got %h want %h", cyc, obs(), want);
      end
      cyc++;
      if (cyc == 1) launch(100, 130, 10, 2, 0);
      else if (exp_q.size() > 0) step();
    end
    go_idle();
  endtask

  // Random sweeps with shadowed inputs, manual_inc and stray starts disturbed mid-sweep.
  task automatic test_random();
    longint s, e, st;
    int     d, n, len;
    bit     c;
    for (int t = 0; t < 12; t++) begin
      s = $urandom_range(0, 32'(MAXV));
      if ($urandom_range(0, 3) == 0) s = MAXV - $urandom_range(0, 40);
      st = $urandom_range(1, 3000);
      e = s + $urandom_range(0, 4) * st + $urandom_range(0, 32'(st - 1));
      if (e > MAXV) e = MAXV;
      d = $urandom_range(0, 3);
      c = 1'($urandom_range(0, 1));
      len = int'((e - s) / st) + 1;
      n = c ? 2 * len * (d + 1) + 2 : len * (d + 1) + 3;
      build_sweep(s, e, st, d, c, n);
      launch(s, e, st, d, c);
      cyc = 0;
      while (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        n_tests++;
        if (obs() !== want) begin
          n_fail++;
          $display("FAIL random t%0d c%0d got %h want %h", t, cyc, obs(), want);
        end
        cyc++;
        manual_inc = PW'($urandom);
        f_start = PW'($urandom); f_stop = PW'($urandom); f_step = PW'($urandom);
        dwell = DW'($urandom); cont = 1'($urandom);
        start = want[W-1] && ($urandom_range(0, 3) == 0);
        if (exp_q.size() > 0) step();
      end
      start = 1'b0;
      go_idle();
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_single();
    test_continuous();
    test_overflow();
    test_reject();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
